// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   readReg,
    output logic [NUM_RD*DATA_W-1:0]   readData,
    output logic [NUM_RD-1:0]          readBusy,
    input  logic                       issueValid,
    input  logic [ADDR_W-1:0]          issueReg,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic                       flush,
    output logic [ADDR_W:0]            busyCount,
    output logic                       full
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_BUSY = (ADDR_W+1)'(DEPTH - ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;
    logic              wr_ok, iss_ok;

    assign wr_ok  = regWrite && !(ZERO_REG != 0 && writeReg == '0);
    assign iss_ok = issueValid && !flush && !(ZERO_REG != 0 && issueReg == '0);

    // Issue is applied after writeback so a same-register issue leaves the bit set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[writeReg] = writeData;
            busy_d[writeReg] = 1'b0;
        end
        if (flush)
            busy_d = '0;
        else if (iss_ok)
            busy_d[issueReg] = 1'b1;
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busyCount = busy_count_q;
    assign full      = busy_count_q == MAX_BUSY;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero;
        assign ra   = readReg[g*ADDR_W +: ADDR_W];
        assign zero = ZERO_REG != 0 && ra == '0;
`ifdef REGFILE_BYPASS_EN
        logic byp;
        assign byp = wr_ok && writeReg == ra;
        assign readData[g*DATA_W +: DATA_W] = zero ? '0 : byp ? writeData : regs_q[ra];
        assign readBusy[g] = zero ? 1'b0 : byp ? (issueValid && issueReg == ra) : busy_q[ra];
`else
        assign readData[g*DATA_W +: DATA_W] = zero ? '0 : regs_q[ra];
        assign readBusy[g] = zero ? 1'b0 : busy_q[ra];
`endif
    end
endmodule
